// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } nsa_state_t;

  // Index counter width; a single-nibble configuration still needs one bit.
  function automatic int idxWidth(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_nibble_add_cin.sv
// Combinational 4-bit ripple-carry slice with carry-in, time-shared by the serial adder.
module nibble_add_cin
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] rippleC;

  assign rippleC[0] = cin;

  // Each bit: sum is the parity of its inputs, carry is their majority.
  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign sum[i]         = a[i] ^ b[i] ^ rippleC[i];
    assign rippleC[i + 1] = (a[i] & b[i]) | (a[i] & rippleC[i]) | (b[i] & rippleC[i]);
  end

  assign cout = rippleC[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that processes one nibble per clock, LSB first, with valid/ready on both sides.
// Optional subtract mode (A-B) is enabled by defining NSA_SUBTRACT_EN.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef NSA_SUBTRACT_EN
  input  logic                        sub,
`endif
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                        carry_out,
  output logic                        busy
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idxWidth(NIBBLES);
  localparam logic [IW-1:0] LastIdx = IW'(NIBBLES - 1);

  nsa_state_t    state_q, state_d;
  logic [W-1:0]  opA_q, opA_d;
  logic [W-1:0]  opB_q, opB_d;
  logic [W-1:0]  result_q, result_d;
  logic [IW-1:0] index_q, index_d;
  logic          carry_q, carry_d;
  logic          carryOut_q, carryOut_d;

  logic [NIBBLE_W-1:0] sliceA, sliceB, sliceSum;
  logic                sliceCout;

  // Select the current nibble of each registered operand for the shared slice.
  always_comb begin
    sliceA = '0;
    sliceB = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (index_q == IW'(i)) begin
        sliceA = opA_q[i*NIBBLE_W +: NIBBLE_W];
        sliceB = opB_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_add_cin u_slice (
    .a   (sliceA),
    .b   (sliceB),
    .cin (carry_q),
    .sum (sliceSum),
    .cout(sliceCout)
  );

  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    result_d   = result_q;
    index_d    = index_q;
    carry_d    = carry_q;
    carryOut_d = carryOut_q;
    in_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && in_ready) begin
          opA_d   = op_a;
          index_d = '0;
`ifdef NSA_SUBTRACT_EN
          // A-B is computed as A + ~B + 1.
          opB_d   = sub ? ~op_b : op_b;
          carry_d = sub;
`else
          opB_d   = op_b;
          carry_d = 1'b0;
`endif
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (index_q == IW'(i)) begin
            result_d[i*NIBBLE_W +: NIBBLE_W] = sliceSum;
          end
        end
        carry_d = sliceCout;
        if (index_q == LastIdx) begin
          carryOut_d = sliceCout;
          index_d    = '0;
          state_d    = DONE;
        end else begin
          index_d = index_q + IW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      result_q   <= '0;
      index_q    <= '0;
      carry_q    <= 1'b0;
      carryOut_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      result_q   <= result_d;
      index_q    <= index_d;
      carry_q    <= carry_d;
      carryOut_q <= carryOut_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign carry_out = carryOut_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NIBBLES=4 main instance, NIBBLES=2 side instance).
// Subtract cases are exercised when NSA_SUBTRACT_EN is defined.
module tb_nibble_serial_adder;

  localparam int Nibbles = 4;
  localparam int W       = 4 * Nibbles;
`ifdef NSA_SUBTRACT_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic         co;
  } expT;

  logic         clk = 1'b0;
  logic         rst;
  logic         inValid, inReady, outValid, outReady, carryOut, busy, subIn;
  logic [W-1:0] opA, opB, result;

  logic         inValid2, inReady2, outValid2, outReady2, carryOut2, busy2;
  logic [7:0]   opA2, opB2, result2;

  int  checks = 0;
  int  errors = 0;
  int  cycleCount = 0;
  int  modelAccepts = 0;
  int  dutAccepts = 0;
  expT expQ[$];
  int  acceptQ[$];
  bit  headSeen = 1'b0;
  bit  randReady = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  nibble_serial_adder #(.NIBBLES(Nibbles)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef NSA_SUBTRACT_EN
    .sub      (subIn),
`endif
    .in_valid (inValid),
    .in_ready (inReady),
    .op_a     (opA),
    .op_b     (opB),
    .out_valid(outValid),
    .out_ready(outReady),
    .result   (result),
    .carry_out(carryOut),
    .busy     (busy)
  );

  nibble_serial_adder #(.NIBBLES(2)) dutNarrow (
    .clk      (clk),
    .rst      (rst),
`ifdef NSA_SUBTRACT_EN
    .sub      (1'b0),
`endif
    .in_valid (inValid2),
    .in_ready (inReady2),
    .op_a     (opA2),
    .op_b     (opB2),
    .out_valid(outValid2),
    .out_ready(outReady2),
    .result   (result2),
    .carry_out(carryOut2),
    .busy     (busy2)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic; carry_out is the bit above the sum, or "no borrow" for subtract.
  function automatic expT refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    expT          e;
    logic [W:0]   full;
    if (s) begin
      e.res = a - b;
      e.co  = (a >= b);
    end else begin
      full  = {1'b0, a} + {1'b0, b};
      e.res = full[W-1:0];
      e.co  = full[W];
    end
    return e;
  endfunction

  task automatic pushExpected(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    expQ.push_back(refModel(a, b, s));
    acceptQ.push_back(cycleCount + 1);
    modelAccepts++;
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int waitCycles = 0;
    @(posedge clk); #1;
    inValid = 1'b1;
    opA     = a;
    opB     = b;
    subIn   = s & SubEn;
    while (!inReady && waitCycles < 50) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!inReady) begin
      checkOutput("accept timeout", 32'(inReady), 1);
      inValid = 1'b0;
      return;
    end
    pushExpected(a, b, s & SubEn);
    @(posedge clk); #1;
    inValid = 1'b0;
    opA     = W'($urandom);
    opB     = W'($urandom);
    subIn   = 1'($urandom) & SubEn;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain pending jobs", expQ.size(), 0);
  endtask

  task automatic applyNarrow(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] full;
    int         n = 0;
    full = {1'b0, a} + {1'b0, b};
    @(posedge clk); #1;
    inValid2 = 1'b1;
    opA2     = a;
    opB2     = b;
    checkOutput("narrow in_ready", 32'(inReady2), 1);
    @(posedge clk); #1;
    inValid2 = 1'b0;
    while (!outValid2 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("narrow latency", n, 2);
    checkOutput("narrow result", 32'(result2), 32'(full[7:0]));
    checkOutput("narrow carry_out", 32'(carryOut2), 32'(full[8]));
    @(posedge clk); #1;
    checkOutput("narrow in_ready after handshake", 32'(inReady2), 1);
  endtask

  // Monitor: every cycle out_valid is high, the DUT must present the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && inValid && inReady) dutAccepts++;
    if (!rst && outValid) begin
      checkOutput("in_ready/busy while valid", {30'd0, inReady, busy}, 32'b01);
      if (expQ.size() == 0) begin
        checkOutput("unexpected out_valid", 32'(outValid), 0);
      end else begin
        if (!headSeen) begin
          checkOutput("latency", cycleCount - acceptQ[0], Nibbles);
          headSeen = 1'b1;
        end
        checkOutput("result", 32'(result), 32'(expQ[0].res));
        checkOutput("carry_out", 32'(carryOut), 32'(expQ[0].co));
        if (outReady) begin
          void'(expQ.pop_front());
          void'(acceptQ.pop_front());
          headSeen = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (randReady) outReady = 1'($urandom);
    end
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: time limit reached with %0d jobs pending", expQ.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges[$];
    int n;

    rst = 1'b1; inValid = 1'b0; outReady = 1'b0; subIn = 1'b0; opA = '0; opB = '0;
    inValid2 = 1'b0; outReady2 = 1'b1; opA2 = '0; opB2 = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(inReady), 0);
    checkOutput("reset out_valid", 32'(outValid), 0);
    checkOutput("reset result", 32'(result), 0);
    checkOutput("reset carry_out", 32'(carryOut), 0);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("narrow reset in_ready", 32'(inReady2), 0);
    rst = 1'b0;
    #1;
    checkOutput("idle in_ready", 32'(inReady), 1);

    $display("[TB] directed additions");
    outReady = 1'b1;
    applyStimulus(16'h1234, 16'h1111, 1'b0);
    waitDrain(20);
    checkOutput("in_ready after first job", 32'(inReady), 1);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    waitDrain(20);
    applyStimulus(16'h0FF0, 16'h0010, 1'b0);
    waitDrain(20);

    $display("[TB] backpressure");
    outReady = 1'b0;
    applyStimulus(16'h8421, 16'h9999, 1'b0);
    n = 0;
    while (!outValid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("backpressure out_valid", 32'(outValid), 1);
    repeat (10) begin
      @(posedge clk); #1;
      inValid = 1'($urandom);
      opA     = W'($urandom);
      opB     = W'($urandom);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    waitDrain(10);
    checkOutput("in_ready after backpressure", 32'(inReady), 1);

    $display("[TB] reset mid-operation");
    applyStimulus(16'hABCD, 16'h1234, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    void'(expQ.pop_back());
    void'(acceptQ.pop_back());
    checkOutput("post-reset out_valid", 32'(outValid), 0);
    checkOutput("post-reset result", 32'(result), 0);
    checkOutput("post-reset busy", 32'(busy), 0);
    checkOutput("post-reset in_ready", 32'(inReady), 1);
    applyStimulus(16'h0001, 16'h0002, 1'b0);
    waitDrain(20);

    $display("[TB] back-to-back");
    @(posedge clk); #1;
    inValid = 1'b1;
    for (int i = 0; i < 80 && edges.size() < 5; i++) begin
      opA   = W'($urandom);
      opB   = W'($urandom);
      subIn = 1'($urandom) & SubEn;
      if (inReady) begin
        pushExpected(opA, opB, subIn);
        edges.push_back(cycleCount + 1);
      end
      @(posedge clk); #1;
    end
    inValid = 1'b0;
    checkOutput("back-to-back accepts", edges.size(), 5);
    for (int i = 1; i < edges.size(); i++) begin
      checkOutput("back-to-back spacing", edges[i] - edges[i-1], Nibbles + 2);
    end
    waitDrain(40);

`ifdef NSA_SUBTRACT_EN
    $display("[TB] subtract");
    applyStimulus(16'h0005, 16'h0007, 1'b1);
    waitDrain(20);
    applyStimulus(16'h0007, 16'h0005, 1'b1);
    waitDrain(20);
`endif

    $display("[TB] random jobs with random out_ready");
    randReady = 1'b1;
    repeat (15) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    @(posedge clk); #1;
    randReady = 1'b0;
    outReady  = 1'b1;
    waitDrain(100);

    $display("[TB] two-nibble instance");
    applyNarrow(8'hFF, 8'h01);
    applyNarrow(8'h5A, 8'h3C);

    checkOutput("acceptance count", dutAccepts, modelAccepts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder that adds two NIBBLES*4-bit operands one 4-bit slice per clock, least significant nibble first.
- Carry is held in a register between slices.
- Sits between a producer that issues operand pairs and a consumer that takes the sum. Both sides use valid/ready handshakes.
- Reuses the team's 4-bit ripple-carry slice, extended with a carry-in.

Parameters:
- NIBBLES, 4, number of 4-bit slices. Operand/result width is 4*NIBBLES. Legal range is 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- op_a  input  4*NIBBLES  operand A
- op_b  input  4*NIBBLES  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  4*NIBBLES  sum, modulo 2^(4*NIBBLES)
- carry_out  output  1  carry out of the most significant nibble
- busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result=0, carry_out=0, busy=0, internal carry=0, nibble index=0, operand registers=0. While rst=1, in_ready is forced to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register op_a and op_b, clear carry, set index=0, go to RUN.
  - No operand is captured without the handshake.
- RUN:
  - in_ready=0.
  - Each cycle, the slice adds nibble[index] of A, nibble[index] of B and the carry register.
  - The slice sum is written into result nibble[index]; the carry register takes the slice carry-out; index increments.
  - When index==NIBBLES-1, go to DONE and load carry_out from the slice carry-out.
  - RUN lasts exactly NIBBLES cycles.
- DONE:
  - out_valid=1; result and carry_out are held stable.
  - On out_ready=1, go to IDLE (out_valid=0 next cycle).
  - Operands are never accepted in DONE. There is no overlap between jobs.
- Latency: the acceptance edge is E0. out_valid is high after edge E(NIBBLES). Minimum job-to-job spacing is NIBBLES+2 cycles.
- Result nibbles above index are stale while RUN is in progress. Consumers sample only when out_valid=1.
- Arithmetic: slice sum = a^b^cin; slice carry = majority(a,b,cin). There is no saturation. Wrap-around is reported only through carry_out.
- Backpressure: out_ready may stay low indefinitely. out_valid, result and carry_out must not change until the handshake completes.
- Operand stability: op_a and op_b may change freely after E0, because the block works on its registered copies.
- Reset mid-operation: rst in any state returns the block to IDLE with reset values on the next edge. The partial result is discarded; no out_valid pulse is produced.
- in_valid high outside IDLE is ignored; the producer holds it until in_ready.

Optional Feature:
- Macro NSA_SUBTRACT_EN.
- When defined:
  - Adds input port sub (1 bit), sampled only at the acceptance handshake and registered with the operands.
  - sub=1: the B register stores ~op_b and the carry initialises to 1, so result = A-B.
  - carry_out=1 means no borrow (A>=B); carry_out=0 means borrow.
  - sub=0 behaves as plain addition.
- When undefined: no sub port, no inversion logic; the block is add-only.

Decomposition:
- Package nsa_pkg holds:
  - NIBBLE_W=4.
  - Enum nsa_state_t {IDLE, RUN, DONE}.
  - Helper function for the index width, $clog2(NIBBLES).
- One sub-module, nibble_add_cin: combinational 4-bit ripple adder with inputs a[3:0], b[3:0], cin and outputs sum[3:0], cout. It is instantiated once and time-multiplexed by index.
- The FSM, index counter and registers live in the top module.

Test Plan:
- NIBBLES=4, op_a=0x1234, op_b=0x1111, out_ready=1 -> out_valid 4 cycles after acceptance, result=0x2345, carry_out=0, then in_ready=1 the following cycle.
- op_a=0xFFFF, op_b=0x0001 -> result=0x0000, carry_out=1. Also op_a=0x0FF0, op_b=0x0010 -> result=0x1000, carry_out=0 (carry crosses a nibble boundary).
- out_ready held low 10 cycles after out_valid, with op_a/op_b/in_valid toggling -> result/carry_out stable, in_ready=0 throughout. Only one acceptance occurs, after the output handshake.
- rst asserted on the 2nd RUN cycle of job 0xABCD+0x1234 -> next cycle IDLE, out_valid=0, result=0. A new job 0x0001+0x0002 then returns 0x0003.
- Back-to-back jobs with in_valid always high and out_ready=1 -> acceptances spaced exactly 6 cycles apart, each result correct. Repeat with NIBBLES=2: 0xFF+0x01 -> result=0x00, carry_out=1.
- With NSA_SUBTRACT_EN and sub=1: 0x0005-0x0007 -> result=0xFFFE, carry_out=0; 0x0007-0x0005 -> result=0x0002, carry_out=1.
